// File: rtl/dds_pkg.sv
// rtl/dds_pkg.sv - shared constants for the dds waveform generator
package dds_pkg;

  // waveform select codes for the downstream 5:1 mux
  localparam logic [2:0] WAVE_SAW      = 3'd0;
  localparam logic [2:0] WAVE_SQUARE   = 3'd1;
  localparam logic [2:0] WAVE_TRIANGLE = 3'd2;
  localparam logic [2:0] WAVE_PULSE    = 3'd3;
  localparam logic [2:0] WAVE_NOISE    = 3'd4;

  // 16-bit fibonacci lfsr taps and default seed
  localparam int          LFSR_W            = 16;
  localparam int          LFSR_TAP_A        = 15;
  localparam int          LFSR_TAP_B        = 13;
  localparam int          LFSR_TAP_C        = 12;
  localparam int          LFSR_TAP_D        = 10;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // next lfsr state; a stuck-at-zero register is reseeded instead of shifted
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                  input logic [LFSR_W-1:0] seed);
    if (s == '0) begin
      return seed;
    end
    return {s[LFSR_W-2:0], s[LFSR_TAP_A] ^ s[LFSR_TAP_B] ^ s[LFSR_TAP_C] ^ s[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/dds_phase_acc.sv
// rtl/dds_phase_acc.sv - tuning word register and phase accumulator (stage 1)
module dds_phase_acc
  import dds_pkg::*;
#(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_en,
  input  logic [N-1:0] ftw_in,
  input  logic         ftw_load,
  input  logic         phase_sync,
  output logic [N-1:0] phase,
  output logic         carry,
  output logic         step_valid
);

  logic [N-1:0] ftw_reg;
  logic [N:0]   sum;

  // sum uses the tuning word as it stands, so a same-cycle load only affects later steps
  assign sum = {1'b0, phase} + {1'b0, ftw_reg};

  // tuning register, phase/carry update with hard sync taking priority, step strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ftw_reg    <= '0;
      phase      <= '0;
      carry      <= 1'b0;
      step_valid <= 1'b0;
    end else begin
      if (ftw_load) begin
        ftw_reg <= ftw_in;
      end
      step_valid <= sample_en;
      if (phase_sync) begin
        phase <= '0;
        carry <= 1'b0;
      end else if (sample_en) begin
        phase <= sum[N-1:0];
        carry <= sum[N];
      end else begin
        carry <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dds_wavegen.sv
// rtl/dds_wavegen.sv - dds waveform generator top; DDS_WAVEGEN_NOISE_EN enables the noise lfsr
module dds_wavegen
  import dds_pkg::*;
#(
  parameter int          M         = 12,
  parameter int          N         = 24,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sample_en,
  input  logic [N-1:0] ftw_in,
  input  logic         ftw_load,
  input  logic         phase_sync,
  input  logic [M-1:0] duty,
  output logic [M-1:0] saw,
  output logic [M-1:0] square,
  output logic [M-1:0] triangle,
  output logic [M-1:0] pulse,
  output logic [M-1:0] noise,
  output logic         out_valid,
  output logic         wrap
);

  logic [N-1:0] phase;
  logic         carry;
  logic         step_valid;

  // the triangle needs one bit below the saw slice, so the phase must be wider than M
  if (N - 1 < M) begin : g_bad_width
    $error("dds_wavegen: N-1 must be >= M");
  end
  if (LFSR_SEED == 16'h0000) begin : g_bad_seed
    $error("dds_wavegen: LFSR_SEED must be nonzero");
  end

  // phase bits below the triangle slice never reach an output
  if (N - M - 2 >= 0) begin : g_low_bits
    logic unused_phase_low;
    assign unused_phase_low = ^phase[N-M-2:0];
  end

  dds_phase_acc #(
    .N(N)
  ) u_phase_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .ftw_in     (ftw_in),
    .ftw_load   (ftw_load),
    .phase_sync (phase_sync),
    .phase      (phase),
    .carry      (carry),
    .step_valid (step_valid)
  );

  // stage 2: shape the freshly updated phase into the deterministic waveforms
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saw       <= '0;
      square    <= '0;
      triangle  <= '0;
      pulse     <= '0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      out_valid <= step_valid;
      wrap      <= step_valid & carry;
      if (step_valid) begin
        saw      <= phase[N-1-:M];
        square   <= {M{phase[N-1]}};
        triangle <= phase[N-1] ? ~phase[N-2-:M] : phase[N-2-:M];
        pulse    <= (phase[N-1-:M] < duty) ? {M{1'b1}} : {M{1'b0}};
      end
    end
  end

`ifdef DDS_WAVEGEN_NOISE_EN
  logic [LFSR_W-1:0] lfsr;
  logic [LFSR_W-1:0] lfsr_nxt;

  assign lfsr_nxt = lfsr_step(lfsr, LFSR_SEED);

  // lfsr advances once per phase wrap; noise shows the state belonging to this sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr  <= LFSR_SEED;
      noise <= '0;
    end else if (step_valid) begin
      if (carry) begin
        lfsr  <= lfsr_nxt;
        noise <= lfsr_nxt[LFSR_W-1-:M];
      end else begin
        noise <= lfsr[LFSR_W-1-:M];
      end
    end
  end
`else
  assign noise = '0;
`endif

endmodule

// File: tb/tb_dds_wavegen.sv
// tb/tb_dds_wavegen.sv - scoreboard testbench for dds_wavegen
module tb_dds_wavegen;

  localparam int          M    = 12;
  localparam int          N    = 24;
  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct packed {
    logic [M-1:0] saw;
    logic [M-1:0] square;
    logic [M-1:0] triangle;
    logic [M-1:0] pulse;
    logic [M-1:0] noise;
    logic         wrap;
  } smp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sample_en;
  logic [N-1:0] ftw_in;
  logic         ftw_load;
  logic         phase_sync;
  logic [M-1:0] duty;
  logic [M-1:0] saw, square, triangle, pulse, noise;
  logic         out_valid, wrap;

  smp_t exp_q[$];
  smp_t obs_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [N-1:0] m_phase;
  logic [N-1:0] m_ftw;
  logic [15:0]  m_lfsr;
  logic [M-1:0] m_duty;

  always #5 clk = ~clk;

  dds_wavegen #(.M(M), .N(N), .LFSR_SEED(SEED)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sample_en  (sample_en),
    .ftw_in     (ftw_in),
    .ftw_load   (ftw_load),
    .phase_sync (phase_sync),
    .duty       (duty),
    .saw        (saw),
    .square     (square),
    .triangle   (triangle),
    .pulse      (pulse),
    .noise      (noise),
    .out_valid  (out_valid),
    .wrap       (wrap)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // reference model of one accumulator step plus output shaping
  task automatic model_step(input logic sync, output smp_t e);
    logic [N:0]   s;
    logic         c;
    logic [M-1:0] t;
    if (sync) begin
      m_phase = '0;
      c = 1'b0;
    end else begin
      s = {1'b0, m_phase} + {1'b0, m_ftw};
      m_phase = s[N-1:0];
      c = s[N];
    end
    e.saw      = m_phase[23:12];
    e.square   = m_phase[23] ? 12'hFFF : 12'h000;
    t          = m_phase[22:11];
    e.triangle = m_phase[23] ? (12'hFFF - t) : t;
    e.pulse    = (e.saw < m_duty) ? 12'hFFF : 12'h000;
    e.wrap     = c;
`ifdef DDS_WAVEGEN_NOISE_EN
    if (c) begin
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    e.noise = m_lfsr[15:4];
`else
    e.noise = 12'h000;
`endif
  endtask

  task automatic drive(input logic se, input logic ld, input logic [N-1:0] f, input logic sync);
    smp_t e;
    @(posedge clk);
    #1;
    sample_en  = se;
    ftw_load   = ld;
    ftw_in     = f;
    phase_sync = sync;
    if (se) begin
      model_step(sync, e);
      exp_q.push_back(e);
    end else if (sync) begin
      m_phase = '0;
    end
    if (ld) m_ftw = f;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 10; i++) begin
      idle();
      if (exp_q.size() == 0) break;
    end
    idle();
    check("drain_pending", exp_q.size(), 0);
  endtask

  task automatic set_duty(input logic [M-1:0] d);
    drain();
    duty   = d;
    m_duty = d;
    idle();
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_phase = '0;
    m_ftw   = '0;
    m_lfsr  = SEED;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_saw"}, saw, 0);
    check({tag, "_square"}, square, 0);
    check({tag, "_triangle"}, triangle, 0);
    check({tag, "_pulse"}, pulse, 0);
    check({tag, "_noise"}, noise, 0);
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_wrap"}, wrap, 0);
  endtask

  // scoreboard: every valid output sample is matched against the oldest expectation
  smp_t mon_e, mon_o;
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      mon_o = '{saw: saw, square: square, triangle: triangle, pulse: pulse,
                noise: noise, wrap: wrap};
      if (exp_q.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("sb_saw", mon_o.saw, mon_e.saw);
        check("sb_square", mon_o.square, mon_e.square);
        check("sb_triangle", mon_o.triangle, mon_e.triangle);
        check("sb_pulse", mon_o.pulse, mon_e.pulse);
        check("sb_noise", mon_o.noise, mon_e.noise);
        check("sb_wrap", mon_o.wrap, mon_e.wrap);
      end
      obs_q.push_back(mon_o);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [M-1:0] tri_tab[4];
    logic [M-1:0] pul_tab[4];
    logic [M-1:0] exp_noise;
    tri_tab = '{12'h800, 12'hFFF, 12'h7FF, 12'h000};
    pul_tab = '{12'hFFF, 12'h000, 12'h000, 12'hFFF};

    rst_n = 1'b0; sample_en = 1'b0; ftw_in = '0; ftw_load = 1'b0;
    phase_sync = 1'b0; duty = '0; m_duty = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // sawtooth / square / first wrap
    obs_q.delete();
    drive(1'b0, 1'b1, 24'h100000, 1'b0);
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, '0, 1'b0);
    drain();
    check("saw16_count", obs_q.size(), 16);
`ifdef DDS_WAVEGEN_NOISE_EN
    exp_noise = 12'h59C;
`else
    exp_noise = 12'h000;
`endif
    if (obs_q.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        check($sformatf("saw16_saw%0d", i), obs_q[i].saw, ((i + 1) * 32'h100) & 32'hFFF);
        check($sformatf("saw16_wrap%0d", i), obs_q[i].wrap, (i == 15) ? 1 : 0);
        if (i < 15) check($sformatf("saw16_sq%0d", i), obs_q[i].square, (i >= 7) ? 12'hFFF : 12'h000);
      end
      check("first_wrap_noise", obs_q[15].noise, exp_noise);
    end

    // triangle and pulse
    set_duty(12'h800);
    obs_q.delete();
    drive(1'b0, 1'b1, 24'h400000, 1'b0);
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, '0, 1'b0);
    drain();
    check("tri_count", obs_q.size(), 8);
    if (obs_q.size() == 8) begin
      for (int i = 0; i < 8; i++) begin
        check($sformatf("tri_%0d", i), obs_q[i].triangle, tri_tab[i % 4]);
        check($sformatf("pulse_%0d", i), obs_q[i].pulse, pul_tab[i % 4]);
      end
    end

    // same-cycle ftw_load uses old word; phase_sync with sample_en
    obs_q.delete();
    drive(1'b0, 1'b1, 24'h100000, 1'b1);
    drive(1'b1, 1'b1, 24'h200000, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b1);
    drain();
    check("load_sync_count", obs_q.size(), 5);
    if (obs_q.size() == 5) begin
      check("load_old_saw", obs_q[0].saw, 12'h100);
      check("load_new_saw", obs_q[1].saw, 12'h300);
      check("presync_saw", obs_q[3].saw, 12'h700);
      check("sync_saw", obs_q[4].saw, 12'h000);
      check("sync_wrap", obs_q[4].wrap, 0);
    end

    // no sample_en: outputs hold, no valid
    for (int i = 0; i < 3; i++) begin
      idle();
      check("hold_valid", out_valid, 0);
      check("hold_saw", saw, 12'h000);
    end

    // zero tuning word: phase holds, never wraps
    obs_q.delete();
    drive(1'b0, 1'b1, '0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, '0, 1'b0);
    drain();
    check("ftw0_count", obs_q.size(), 4);
    foreach (obs_q[i]) begin
      check("ftw0_wrap", obs_q[i].wrap, 0);
      check("ftw0_saw", obs_q[i].saw, 12'h000);
    end

    // randomized traffic with a reset in the middle of a stream
    set_duty(12'(($urandom_range(1, 4095))));
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        drive(1'b0, 1'b1, 24'h3A5A5A, 1'b0);
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b0, '0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        sample_en = 1'b0;
        ftw_load = 1'b0;
        phase_sync = 1'b0;
        #1;
        check_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
      end
      drive(($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 1) != 0) ? N'($urandom()) : N'($urandom_range(0, 255) << 16),
            ($urandom_range(0, 15) == 0));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
